// File: rtl/coreahbltoaxi_wrch_wdriver.sv
// AXI write-data channel driver: pops burst beats from the write-data FIFO through a
// 2-entry skid buffer and drives WID/WDATA/WSTRB/WLAST/WVALID under WREADY flow control.
module coreahbltoaxi_wrch_wdriver #(
   parameter int AXI_DWIDTH = 64,
   parameter int ID_WIDTH   = 4
) (
   input  logic                    rdclk,
   input  logic                    rdrst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [3:0]              cmd_len,
   input  logic [ID_WIDTH-1:0]     cmd_id,
   input  logic [AXI_DWIDTH/8-1:0] cmd_strb_first,
   input  logic [AXI_DWIDTH/8-1:0] cmd_strb_last,
   input  logic                    fifo_empty,
   input  logic [AXI_DWIDTH-1:0]   fifo_rddata,
   output logic                    fifo_rdinr,
   output logic [ID_WIDTH-1:0]     WID,
   output logic [AXI_DWIDTH-1:0]   WDATA,
   output logic [AXI_DWIDTH/8-1:0] WSTRB,
   output logic                    WLAST,
   output logic                    WVALID,
   input  logic                    WREADY,
   output logic                    wburst_done
);

   localparam int STRB_W = AXI_DWIDTH / 8;

   typedef enum logic {
      ST_IDLE,
      ST_BURST
   } state_t;

   state_t                  r_state;
   logic [3:0]              r_len;
   logic [ID_WIDTH-1:0]     r_id;
   logic [STRB_W-1:0]       r_strb_first;
   logic [STRB_W-1:0]       r_strb_last;
   logic [4:0]              r_pops_left;
   logic [3:0]              r_beat_cnt;
   logic [1:0]              r_count;
   logic                    r_pop_d;
   logic [AXI_DWIDTH-1:0]   r_buf0;
   logic [AXI_DWIDTH-1:0]   r_buf1;

   logic                    w_hs;
   logic                    w_last_beat;
   logic [2:0]              w_occ;
   logic                    w_pop;
   logic [STRB_W-1:0]       w_strb;

   // Occupancy the buffer will have after this cycle's capture and dequeue.
   assign w_hs        = WVALID & WREADY;
   assign w_last_beat = (r_beat_cnt == r_len);
   assign w_occ       = 3'(r_count) + 3'(r_pop_d) - 3'(w_hs);
   assign w_pop       = (r_state == ST_BURST) & ~fifo_empty & (r_pops_left != 5'd0) & (w_occ < 3'd2);

   assign fifo_rdinr  = w_pop;
   assign cmd_ready   = (r_state == ST_IDLE);
   assign WVALID      = (r_count != 2'd0);
   assign WLAST       = WVALID & w_last_beat;
   assign WDATA       = r_buf0;
   assign WID         = r_id;
   assign wburst_done = w_hs & WLAST;
   assign WSTRB       = w_strb;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_strb = '0;
      if (WVALID) begin
         if (r_len == 4'd0)
            w_strb = r_strb_first & r_strb_last;
         else if (r_beat_cnt == 4'd0)
            w_strb = r_strb_first;
         else if (w_last_beat)
            w_strb = r_strb_last;
         else
            w_strb = '1;
      end
   end

   // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge rdclk) begin
      if (rdrst) begin
         r_state      <= ST_IDLE;
         r_len        <= '0;
         r_id         <= '0;
         r_strb_first <= '0;
         r_strb_last  <= '0;
         r_pops_left  <= '0;
         r_beat_cnt   <= '0;
         r_count      <= '0;
         r_pop_d      <= 1'b0;
         // NOTE: the two data entries are reset as well so WDATA reads zero straight out of reset.
         r_buf0       <= '0;
         r_buf1       <= '0;
      end else begin
         r_pop_d <= w_pop;
         if (w_pop)
            r_pops_left <= r_pops_left - 5'd1;

         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_state      <= ST_BURST;
                  r_len        <= cmd_len;
                  r_id         <= cmd_id;
                  r_strb_first <= cmd_strb_first;
                  r_strb_last  <= cmd_strb_last;
                  r_pops_left  <= {1'b0, cmd_len} + 5'd1;
                  r_beat_cnt   <= '0;
               end
            end
            ST_BURST: begin
               if (w_hs) begin
                  if (w_last_beat)
                     r_state <= ST_IDLE;
                  else
                     r_beat_cnt <= r_beat_cnt + 4'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // Head always drives WDATA; capture and dequeue may coincide.
         if (r_pop_d && w_hs) begin
            if (r_count == 2'd1) begin
               r_buf0 <= fifo_rddata;
            end else begin
               r_buf0 <= r_buf1;
               r_buf1 <= fifo_rddata;
            end
         end else if (w_hs) begin
            r_buf0  <= r_buf1;
            r_count <= r_count - 2'd1;
         end else if (r_pop_d) begin
            if (r_count == 2'd0)
               r_buf0 <= fifo_rddata;
            else
               r_buf1 <= fifo_rddata;
            r_count <= r_count + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_coreahbltoaxi_wrch_wdriver.sv
// Directed bench for coreahbltoaxi_wrch_wdriver: a burst table plus hand-written
// sequences for exact pop/beat timing, FIFO underrun, back-to-back bursts and reset.
module tb_coreahbltoaxi_wrch_wdriver;

   localparam int DW = 64;
   localparam int IW = 4;
   localparam int SW = DW / 8;

   logic          rdclk = 1'b0;
   logic          rdrst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [3:0]    cmd_len;
   logic [IW-1:0] cmd_id;
   logic [SW-1:0] cmd_strb_first;
   logic [SW-1:0] cmd_strb_last;
   logic          fifo_empty;
   logic [DW-1:0] fifo_rddata;
   logic          fifo_rdinr;
   logic [IW-1:0] WID;
   logic [DW-1:0] WDATA;
   logic [SW-1:0] WSTRB;
   logic          WLAST;
   logic          WVALID;
   logic          WREADY;
   logic          wburst_done;

   always #5 rdclk = ~rdclk;

   coreahbltoaxi_wrch_wdriver #(.AXI_DWIDTH(DW), .ID_WIDTH(IW)) dut (
      .rdclk          (rdclk),
      .rdrst          (rdrst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_len        (cmd_len),
      .cmd_id         (cmd_id),
      .cmd_strb_first (cmd_strb_first),
      .cmd_strb_last  (cmd_strb_last),
      .fifo_empty     (fifo_empty),
      .fifo_rddata    (fifo_rddata),
      .fifo_rdinr     (fifo_rdinr),
      .WID            (WID),
      .WDATA          (WDATA),
      .WSTRB          (WSTRB),
      .WLAST          (WLAST),
      .WVALID         (WVALID),
      .WREADY         (WREADY),
      .wburst_done    (wburst_done)
   );

   // Behavioural FIFO: data appears on fifo_rddata the cycle after the pop.
   logic [DW-1:0] fifo_mem [0:255];
   int unsigned   fifo_wr_idx = 0;
   int unsigned   fifo_rd_idx = 0;
   int unsigned   pop_total   = 0;
   int unsigned   empty_pops  = 0;

   assign fifo_empty = (fifo_wr_idx == fifo_rd_idx);

   always @(posedge rdclk) begin
      if (fifo_rdinr) begin
         if (fifo_empty) begin
            empty_pops <= empty_pops + 1;
         end else begin
            fifo_rddata <= fifo_mem[fifo_rd_idx];
            fifo_rd_idx <= fifo_rd_idx + 1;
         end
         pop_total <= pop_total + 1;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge rdclk);
      #1;
   endtask

   task automatic sample();
      @(negedge rdclk);
   endtask

   task automatic fifo_push(input logic [DW-1:0] d);
      fifo_mem[fifo_wr_idx] = d;
      fifo_wr_idx++;
   endtask

   typedef struct {
      logic [3:0]    len;
      logic [IW-1:0] id;
      logic [SW-1:0] sf;
      logic [SW-1:0] sl;
      logic [15:0]   rdy;
      bit            noise;
      logic [SW-1:0] exp_first;
      logic [SW-1:0] exp_last;
   } vec_t;

   vec_t vecs[5];

   // Presents one command and follows it to its final handshake; returns at the
   // negedge of the done cycle.
   task automatic run_burst(input vec_t v, input logic [DW-1:0] base, input bit expect_immediate);
      int            wait_cyc;
      int            beat;
      int unsigned   pops0;
      bit            stalled;
      logic [DW-1:0] prev_data;
      logic [SW-1:0] prev_strb;
      logic [SW-1:0] exp_strb;

      for (int i = 0; i <= int'(v.len); i++) fifo_push(base + DW'(i));
      cmd_valid      = 1'b1;
      cmd_len        = v.len;
      cmd_id         = v.id;
      cmd_strb_first = v.sf;
      cmd_strb_last  = v.sl;
      WREADY         = 1'b0;
      wait_cyc       = 0;
      sample();
      while (!cmd_ready && wait_cyc < 50) begin
         next_cycle();
         sample();
         wait_cyc++;
      end
      check("cmd_accept", cmd_ready, 1);
      if (expect_immediate) check("cmd_wait_cycles", wait_cyc, 0);
      pops0 = pop_total;
      next_cycle();
      if (v.noise) begin
         cmd_id  = ~v.id;
         cmd_len = 4'hF;
      end else begin
         cmd_valid = 1'b0;
      end

      beat    = 0;
      stalled = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         WREADY = v.rdy[cyc % 16];
         sample();
         if (stalled) begin
            check("stall_hold_valid", WVALID, 1);
            check("stall_hold_data", WDATA, prev_data);
            check("stall_hold_strb", WSTRB, prev_strb);
         end
         if (WVALID) begin
            if (v.len == 4'd0 || beat == 0) exp_strb = v.exp_first;
            else if (beat == int'(v.len))   exp_strb = v.exp_last;
            else                            exp_strb = '1;
            if (WREADY) begin
               check("beat_data", WDATA, base + DW'(beat));
               check("beat_strb", WSTRB, exp_strb);
               check("beat_wid", WID, v.id);
               check("beat_wlast", WLAST, beat == int'(v.len));
               check("beat_done", wburst_done, beat == int'(v.len));
               beat++;
               stalled = 1'b0;
            end else begin
               stalled   = 1'b1;
               prev_data = WDATA;
               prev_strb = WSTRB;
               check("stall_no_done", wburst_done, 0);
            end
         end
         if (beat > int'(v.len)) break;
         next_cycle();
      end
      cmd_valid = 1'b0;
      check("burst_complete", beat, int'(v.len) + 1);
      check("burst_pop_count", pop_total - pops0, int'(v.len) + 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int            beat;
      bit            gap_seen;
      bit            seen;
      logic [DW-1:0] base;

      vecs[0] = '{len: 4'd3,  id: 4'h1, sf: 8'hFF, sl: 8'hFF, rdy: 16'hFFFF, noise: 1'b0, exp_first: 8'hFF, exp_last: 8'hFF};
      vecs[1] = '{len: 4'd0,  id: 4'h2, sf: 8'hF0, sl: 8'hFF, rdy: 16'hFFFF, noise: 1'b0, exp_first: 8'hF0, exp_last: 8'hF0};
      vecs[2] = '{len: 4'd7,  id: 4'h6, sf: 8'hFE, sl: 8'h7F, rdy: 16'h5555, noise: 1'b1, exp_first: 8'hFE, exp_last: 8'h7F};
      vecs[3] = '{len: 4'd1,  id: 4'hA, sf: 8'h0F, sl: 8'h3C, rdy: 16'hFFFF, noise: 1'b0, exp_first: 8'h0F, exp_last: 8'h3C};
      vecs[4] = '{len: 4'd15, id: 4'hF, sf: 8'h80, sl: 8'h01, rdy: 16'hF0F3, noise: 1'b0, exp_first: 8'h80, exp_last: 8'h01};

      rdrst          = 1'b1;
      cmd_valid      = 1'b0;
      cmd_len        = '0;
      cmd_id         = '0;
      cmd_strb_first = '0;
      cmd_strb_last  = '0;
      WREADY         = 1'b0;
      next_cycle();
      next_cycle();
      rdrst = 1'b0;
      sample();
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_wvalid", WVALID, 0);
      check("rst_wlast", WLAST, 0);
      check("rst_rdinr", fifo_rdinr, 0);
      check("rst_done", wburst_done, 0);
      check("rst_wdata", WDATA, 0);
      check("rst_wstrb", WSTRB, 0);
      check("rst_wid", WID, 0);
      next_cycle();

      // Exact timing, len=3 with WREADY high: pops t0..t3, beats t2..t5.
      base = 64'hD100_0000_0000_0000;
      for (int i = 0; i < 4; i++) fifo_push(base + DW'(i));
      cmd_valid      = 1'b1;
      cmd_len        = 4'd3;
      cmd_id         = 4'h9;
      cmd_strb_first = 8'hFF;
      cmd_strb_last  = 8'hFF;
      WREADY         = 1'b1;
      sample();
      check("t1_cmd_ready", cmd_ready, 1);
      next_cycle();
      cmd_valid = 1'b0;
      for (int t = 0; t < 7; t++) begin
         sample();
         check("t1_rdinr", fifo_rdinr, t <= 3);
         check("t1_wvalid", WVALID, t >= 2 && t <= 5);
         check("t1_wlast", WLAST, t == 5);
         check("t1_done", wburst_done, t == 5);
         check("t1_cmd_ready", cmd_ready, t == 6);
         if (t >= 2 && t <= 5) check("t1_wdata", WDATA, base + DW'(t - 2));
         next_cycle();
      end

      for (int k = 0; k < 5; k++) begin
         run_burst(vecs[k], 64'hA000_0000_0000_0000 + 64'(k) * 64'h100, 1'b0);
         next_cycle();
      end

      // FIFO underrun after two of four beats, refilled at cycle 7.
      base = 64'hC400_0000_0000_0000;
      fifo_push(base);
      fifo_push(base + 1);
      cmd_valid      = 1'b1;
      cmd_len        = 4'd3;
      cmd_id         = 4'h4;
      cmd_strb_first = 8'hFF;
      cmd_strb_last  = 8'hFF;
      WREADY         = 1'b1;
      sample();
      check("gap_cmd_ready", cmd_ready, 1);
      next_cycle();
      cmd_valid = 1'b0;
      beat      = 0;
      gap_seen  = 1'b0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (cyc == 7) begin
            fifo_push(base + 2);
            fifo_push(base + 3);
         end
         sample();
         if (WVALID) begin
            if (beat == 2) check("gap_resume_cycle", cyc, 9);
            check("gap_wdata", WDATA, base + DW'(beat));
            check("gap_wlast", WLAST, beat == 3);
            check("gap_done", wburst_done, beat == 3);
            beat++;
         end else if (beat > 0) begin
            gap_seen = 1'b1;
         end
         if (beat == 4) break;
         next_cycle();
      end
      check("gap_beats", beat, 4);
      check("gap_seen", gap_seen, 1);
      next_cycle();

      // Back-to-back bursts, id 3 then id 5.
      run_burst('{len: 4'd1, id: 4'h3, sf: 8'h0F, sl: 8'hF0, rdy: 16'hFFFF, noise: 1'b0,
                  exp_first: 8'h0F, exp_last: 8'hF0}, 64'hB300_0000_0000_0000, 1'b0);
      check("b2b_busy_at_done", cmd_ready, 0);
      next_cycle();
      run_burst('{len: 4'd2, id: 4'h5, sf: 8'h33, sl: 8'hCC, rdy: 16'hFFFF, noise: 1'b0,
                  exp_first: 8'h33, exp_last: 8'hCC}, 64'hB500_0000_0000_0000, 1'b1);
      next_cycle();

      // Reset mid-burst while beat 2 of a len=15 burst is on the bus.
      base = 64'hE700_0000_0000_0000;
      for (int i = 0; i < 16; i++) fifo_push(base + DW'(i));
      cmd_valid      = 1'b1;
      cmd_len        = 4'd15;
      cmd_id         = 4'h7;
      cmd_strb_first = 8'hFF;
      cmd_strb_last  = 8'hFF;
      WREADY         = 1'b1;
      sample();
      check("rst2_cmd_ready", cmd_ready, 1);
      next_cycle();
      cmd_valid = 1'b0;
      beat      = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         sample();
         if (WVALID && beat == 2) begin
            rdrst = 1'b1;
            break;
         end
         if (WVALID) beat++;
         next_cycle();
      end
      check("rst2_reached_beat2", rdrst, 1);
      next_cycle();
      rdrst = 1'b0;
      sample();
      check("rst2_wvalid", WVALID, 0);
      check("rst2_cmd_ready", cmd_ready, 1);
      check("rst2_done", wburst_done, 0);
      check("rst2_wlast", WLAST, 0);
      check("rst2_rdinr", fifo_rdinr, 0);
      check("rst2_wdata", WDATA, 0);
      check("rst2_wstrb", WSTRB, 0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         sample();
         if (wburst_done || WVALID) seen = 1'b1;
      end
      check("rst2_quiet_after", seen, 0);

      check("no_pop_when_empty", empty_pops, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
